// File: rtl/branch_predict_if.sv
// branch_predict_if: Fetch lookup, Execute resolve and flush/redirect signals of the branch predictor.
interface branch_predict_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int STAT_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] f_pc_i;
  logic                  f_predict_taken_o;
  logic                  e_valid_i;
  logic                  e_branch_i;
  logic                  e_jlink_i;
  logic [2:0]            e_func3_i;
  logic                  e_zero_i;
  logic                  e_lt_i;
  logic                  e_ltu_i;
  logic [ADDR_WIDTH-1:0] e_pc_i;
  logic                  e_predicted_i;
  logic [ADDR_WIDTH-1:0] e_target_i;
  logic [ADDR_WIDTH-1:0] e_pc_plus4_i;
  logic                  flush_o;
  logic [ADDR_WIDTH-1:0] redirect_pc_o;
  logic [STAT_WIDTH-1:0] branch_count_o;
  logic [STAT_WIDTH-1:0] mispredict_count_o;
  modport master (
    output f_pc_i, e_valid_i, e_branch_i, e_jlink_i, e_func3_i, e_zero_i, e_lt_i, e_ltu_i,
           e_pc_i, e_predicted_i, e_target_i, e_pc_plus4_i,
    input  f_predict_taken_o, flush_o, redirect_pc_o, branch_count_o, mispredict_count_o
  );
  modport slave (
    input  f_pc_i, e_valid_i, e_branch_i, e_jlink_i, e_func3_i, e_zero_i, e_lt_i, e_ltu_i,
           e_pc_i, e_predicted_i, e_target_i, e_pc_plus4_i,
    output f_predict_taken_o, flush_o, redirect_pc_o, branch_count_o, mispredict_count_o
  );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: B-type/jal resolve, 2-bit counter BHT and registered mispredict flush.
// Define BRANCH_STATS_EN to build the saturating branch/mispredict performance counters.
module branch_predict_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int STAT_WIDTH  = 32
) (
  input logic clk,
  input logic rst,
  branch_predict_if.slave bus
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0] bht_q [BHT_ENTRIES];
  logic [1:0] bht_d [BHT_ENTRIES];
  logic [IW-1:0] f_idx, e_idx;
  logic [1:0] cnt;
  logic cond, legal, qual, taken, mis, upd;
  logic flush_d, flush_q;
  logic [ADDR_WIDTH-1:0] redirect_d, redirect_q;
  logic unused_bits;
  assign f_idx = bus.f_pc_i[IW+1:2];
  assign e_idx = bus.e_pc_i[IW+1:2];
  assign unused_bits = ^{bus.f_pc_i[ADDR_WIDTH-1:IW+2], bus.f_pc_i[1:0],
                         bus.e_pc_i[ADDR_WIDTH-1:IW+2], bus.e_pc_i[1:0]};
  assign bus.f_predict_taken_o = bht_q[f_idx][1];
  assign bus.flush_o = flush_q;
  assign bus.redirect_pc_o = redirect_q;
  // func3[2:1] selects the flag, func3[0] inverts it
  always_comb begin
    cond = bus.e_func3_i[0] ^ (bus.e_func3_i[2:1] == 2'b00 ? bus.e_zero_i :
                               bus.e_func3_i[2:1] == 2'b10 ? bus.e_lt_i : bus.e_ltu_i);
    legal = bus.e_func3_i[2:1] != 2'b01;
    qual = bus.e_valid_i & (bus.e_branch_i | bus.e_jlink_i) & ~flush_q;
    taken = bus.e_jlink_i | (legal & cond);
    mis = qual & (taken != bus.e_predicted_i);
    upd = qual & ~bus.e_jlink_i & legal;
    flush_d = mis;
    redirect_d = mis ? (taken ? bus.e_target_i : bus.e_pc_plus4_i) : '0;
    cnt = bht_q[e_idx];
    bht_d = bht_q;
    if (upd) bht_d[e_idx] = taken ? (cnt == 2'b11 ? cnt : cnt + 2'd1) : (cnt == 2'b00 ? cnt : cnt - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      flush_q <= 1'b0;
      redirect_q <= '0;
    end else begin
      bht_q <= bht_d;
      flush_q <= flush_d;
      redirect_q <= redirect_d;
    end
  end
`ifdef BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0] branch_cnt_d, branch_cnt_q, mis_cnt_d, mis_cnt_q;
  always_comb begin
    branch_cnt_d = (qual && !(&branch_cnt_q)) ? branch_cnt_q + 1'b1 : branch_cnt_q;
    mis_cnt_d = (mis && !(&mis_cnt_q)) ? mis_cnt_q + 1'b1 : mis_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
  assign bus.branch_count_o = branch_cnt_q;
  assign bus.mispredict_count_o = mis_cnt_q;
`else
  assign bus.branch_count_o = '0;
  assign bus.mispredict_count_o = '0;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed resolve/lookup vectors checked by a queue-based monitor.
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predict_if #(.ADDR_WIDTH(32), .STAT_WIDTH(32)) bus ();
  branch_predict_unit #(.ADDR_WIDTH(32), .BHT_ENTRIES(4), .STAT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { int cyc; logic flush; logic [31:0] redir; } res_t;
  typedef struct { int cyc; logic pred; logic [31:0] pc; } look_t;
  res_t  res_q[$];
  look_t look_q[$];
  res_t  r;
  look_t l;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0, n_br = 0, n_mis = 0;
  logic prev_mis = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: flush/redirect due one cycle after each resolve, prediction in the lookup cycle
  always @(negedge clk) begin
    if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
      r = res_q.pop_front();
      n_cmp++;
      if (bus.flush_o !== r.flush) begin
        n_bad++;
        $display("FAIL flush cyc=%0d got=%b exp=%b", cyc, bus.flush_o, r.flush);
      end
      if (r.flush) begin
        n_cmp++;
        if (bus.redirect_pc_o !== r.redir) begin
          n_bad++;
          $display("FAIL redirect cyc=%0d got=%h exp=%h", cyc, bus.redirect_pc_o, r.redir);
        end
      end
    end else if (bus.flush_o === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_flush cyc=%0d got=1 exp=0", cyc);
    end
    if (look_q.size() > 0 && look_q[0].cyc == cyc) begin
      l = look_q.pop_front();
      n_cmp++;
      if (bus.f_predict_taken_o !== l.pred) begin
        n_bad++;
        $display("FAIL lookup pc=%h got=%b exp=%b", l.pc, bus.f_predict_taken_o, l.pred);
      end
    end
  end

  function automatic logic dec(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic br, input logic jl, input logic [2:0] f3, input logic z,
                         input logic lt, input logic ltu, input logic [31:0] pc, input logic pred,
                         input logic [31:0] tgt, input logic exp_taken);
    logic qual, mis;
    bus.e_valid_i = 1'b1;
    bus.e_branch_i = br;
    bus.e_jlink_i = jl;
    bus.e_func3_i = f3;
    bus.e_zero_i = z;
    bus.e_lt_i = lt;
    bus.e_ltu_i = ltu;
    bus.e_pc_i = pc;
    bus.e_predicted_i = pred;
    bus.e_target_i = tgt;
    bus.e_pc_plus4_i = pc + 32'd4;
    qual = !prev_mis;
    mis = qual && (exp_taken != pred);
    res_q.push_back('{cyc + 1, mis, exp_taken ? tgt : pc + 32'd4});
    if (qual) n_br++;
    if (mis) n_mis++;
    prev_mis = mis;
    tick();
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp);
    bus.f_pc_i = pc;
    look_q.push_back('{cyc, exp, pc});
  endtask

  task automatic idle();
    bus.e_valid_i = 1'b0;
    prev_mis = 1'b0;
    tick();
  endtask

  task automatic check_stats();
    logic [31:0] eb, em;
`ifdef BRANCH_STATS_EN
    eb = n_br;
    em = n_mis;
`else
    eb = 0;
    em = 0;
`endif
    n_cmp += 2;
    if (bus.branch_count_o !== eb) begin
      n_bad++;
      $display("FAIL branch_count got=%0d exp=%0d", bus.branch_count_o, eb);
    end
    if (bus.mispredict_count_o !== em) begin
      n_bad++;
      $display("FAIL mispredict_count got=%0d exp=%0d", bus.mispredict_count_o, em);
    end
  endtask

  initial begin
    bus.f_pc_i = '0;
    bus.e_valid_i = 1'b0;
    bus.e_branch_i = 1'b0;
    bus.e_jlink_i = 1'b0;
    bus.e_func3_i = '0;
    bus.e_zero_i = 1'b0;
    bus.e_lt_i = 1'b0;
    bus.e_ltu_i = 1'b0;
    bus.e_pc_i = '0;
    bus.e_predicted_i = 1'b0;
    bus.e_target_i = '0;
    bus.e_pc_plus4_i = '0;
    tick();
    tick();
    rst = 1'b0;
    lookup(32'h100, 1'b0);
    res_q.push_back('{cyc, 1'b0, 32'h0});
    check_stats();
    idle();
    // Train 0x100: WNT -> WT (mispredict) -> ST (correct)
    resolve(1, 0, 3'b000, 1, 0, 0, 32'h100, 0, 32'h200, 1);
    lookup(32'h100, 1'b1);
    idle();
    resolve(1, 0, 3'b000, 1, 0, 0, 32'h100, 1, 32'h200, 1);
    lookup(32'h100, 1'b1);
    idle();
    // Every func3 against every flag combination, predicted not-taken
    for (int f = 0; f < 8; f++)
      for (int g = 0; g < 8; g++) begin
        resolve(1, 0, f[2:0], g[2], g[1], g[0], 32'h104, 0, 32'h300, dec(f[2:0], g[2], g[1], g[0]));
        idle();
      end
    // Illegal func3: not taken, counter untouched
    resolve(1, 0, 3'b010, 1, 1, 1, 32'h108, 1, 32'h500, 0);
    idle();
    resolve(1, 0, 3'b011, 1, 1, 1, 32'h108, 0, 32'h500, 0);
    lookup(32'h108, 1'b0);
    idle();
    resolve(1, 0, 3'b000, 1, 0, 0, 32'h108, 1, 32'h500, 1);
    lookup(32'h108, 1'b1);
    idle();
    // Saturation at ST, then mispredicted not-taken
    resolve(1, 0, 3'b000, 1, 0, 0, 32'h100, 1, 32'h200, 1);
    resolve(1, 0, 3'b000, 1, 0, 0, 32'h100, 1, 32'h200, 1);
    resolve(1, 0, 3'b000, 0, 0, 0, 32'h100, 1, 32'h200, 0);
    lookup(32'h100, 1'b1);
    idle();
    resolve(1, 0, 3'b000, 0, 0, 0, 32'h100, 0, 32'h200, 0);
    lookup(32'h100, 1'b0);
    idle();
    // Saturation at SNT
    resolve(1, 0, 3'b001, 1, 0, 0, 32'h10c, 0, 32'h600, 0);
    resolve(1, 0, 3'b001, 1, 0, 0, 32'h10c, 0, 32'h600, 0);
    resolve(1, 0, 3'b000, 1, 0, 0, 32'h10c, 0, 32'h600, 1);
    lookup(32'h10c, 1'b0);
    idle();
    // jal: flush to target, no counter update; jlink beats branch
    resolve(0, 1, 3'b000, 0, 0, 0, 32'h10c, 0, 32'h700, 1);
    lookup(32'h10c, 1'b0);
    idle();
    resolve(1, 1, 3'b001, 1, 0, 0, 32'h10c, 1, 32'h800, 1);
    lookup(32'h10c, 1'b0);
    idle();
    // Branch in the flush cycle is squashed
    resolve(1, 0, 3'b000, 1, 0, 0, 32'h10c, 0, 32'h900, 1);
    resolve(1, 0, 3'b000, 0, 0, 0, 32'h10c, 1, 32'h900, 0);
    lookup(32'h10c, 1'b1);
    idle();
    // 0x0 and 0x10 share index 0 with four entries
    resolve(1, 0, 3'b000, 1, 0, 0, 32'h10, 0, 32'ha00, 1);
    lookup(32'h0, 1'b1);
    idle();
    check_stats();
    // Reset on the edge ending a mispredicting resolve
    rst = 1'b1;
    bus.e_valid_i = 1'b1;
    bus.e_branch_i = 1'b1;
    bus.e_jlink_i = 1'b0;
    bus.e_func3_i = 3'b000;
    bus.e_zero_i = 1'b0;
    bus.e_pc_i = 32'h0;
    bus.e_predicted_i = 1'b1;
    bus.e_target_i = 32'hb00;
    bus.e_pc_plus4_i = 32'h4;
    res_q.push_back('{cyc + 1, 1'b0, 32'h0});
    tick();
    rst = 1'b0;
    bus.e_valid_i = 1'b0;
    prev_mis = 1'b0;
    n_br = 0;
    n_mis = 0;
    lookup(32'h0, 1'b0);
    check_stats();
    idle();
    lookup(32'h8, 1'b0);
    idle();
    resolve(1, 0, 3'b000, 1, 0, 0, 32'h0, 1, 32'hc00, 1);
    lookup(32'h0, 1'b1);
    idle();
    resolve(1, 0, 3'b100, 0, 1, 0, 32'h4, 0, 32'hd00, 1);
    idle();
    idle();
    check_stats();
    n_cmp++;
    if (res_q.size() != 0 || look_q.size() != 0) begin
      n_bad++;
      $display("FAIL queues_drained got=%0d/%0d exp=0/0", res_q.size(), look_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
